// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the flag-reporting FIFO.
// Pops the FIFO using a conservative occupancy estimate and
// buffers returned words for a valid/ready downstream port.
// Ports:
//   clk, reset_L (async, active-low)
//   Fifo_Empty..Fifo_Full : one-hot occupancy flags (0..4)
//   Error_Fifo            : FIFO error flag
//   Fifo_Data_in          : FIFO read data, valid the cycle after pop
//   out_ready             : downstream accepts data_out
//   pop                   : read request to the FIFO
//   data_out, valid_out   : head of the output buffer
//   Error_Rd              : sticky protocol error
module fifo_reader #(
    parameter int DATA_WIDTH = 6,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  Fifo_Empty,
    input  logic                  Almost_Empty,
    input  logic                  Pausa,
    input  logic                  Almost_Full,
    input  logic                  Fifo_Full,
    input  logic                  Error_Fifo,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic                  out_ready,
    output logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  Error_Rd
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [CW:0]   DEPTH_X  = (CW + 1)'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pop_d1_q, pop_d1_d;
    logic                  pop_d2_q, pop_d2_d;
    logic                  err_q, err_d;

    logic [4:0] flags;
    logic       one_hot;
    logic [2:0] occ;
    logic [1:0] infl;
    logic       room;
    logic       pop_c;
    logic       deq;
    logic       enq;
    logic       ovf;

    always_comb begin
        flags   = {Fifo_Full, Almost_Full, Pausa, Almost_Empty, Fifo_Empty};
        one_hot = (flags != 5'd0) && ((flags & (flags - 5'd1)) == 5'd0);
        // Malformed flags decode as empty so no pop is issued on them.
        occ = 3'd0;
        if (one_hot) begin
            unique case (1'b1)
                flags[0]: occ = 3'd0;
                flags[1]: occ = 3'd1;
                flags[2]: occ = 3'd2;
                flags[3]: occ = 3'd3;
                flags[4]: occ = 3'd4;
            endcase
        end

        // Flags do not yet reflect pops from the last two cycles.
        infl = {1'b0, pop_d1_q} + {1'b0, pop_d2_q};
        // Reserve space for the word still returning from the FIFO.
        room = ({1'b0, cnt_q} + {{CW{1'b0}}, pop_d1_q}) < DEPTH_X;
        pop_c = reset_L && !err_q && (occ > {1'b0, infl}) && room;

        deq = (cnt_q != '0) && out_ready;
        ovf = pop_d1_q && (cnt_q == DEPTH_C) && !deq;
        enq = pop_d1_q && !ovf;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            mem_d[wr_ptr_q] = Fifo_Data_in;
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end

        cnt_d = cnt_q;
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        pop_d1_d = pop_c;
        pop_d2_d = pop_d1_q;
        err_d    = err_q || Error_Fifo || !one_hot || ovf;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            pop_d1_q <= 1'b0;
            pop_d2_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            pop_d1_q <= pop_d1_d;
            pop_d2_q <= pop_d2_d;
            err_q    <= err_d;
        end
    end

    assign pop       = pop_c;
    assign valid_out = (cnt_q != '0);
    assign data_out  = mem_q[rd_ptr_q];
    assign Error_Rd  = err_q;

    // The pop rule reserves space, so a capture never overflows.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset_L) !ovf
    );

endmodule
